piso_shift: RTL and testbench

PISO_SHIFT -- requirements
Module: piso_shift

---
 rtl/piso_shift.sv | 108 ++++++++++
 tb/tb_piso_shift.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/piso_shift.sv
// piso_shift: 4-bit parallel-in / serial-out shifter with ready, valid and done handshake.
// Build option PISO_PARITY_EN appends one even-parity bit after the fourth data bit.
module piso_shift #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic da,
  input  logic db,
  input  logic dc,
  input  logic dd,
  input  logic load,
  output logic ready,
  output logic sout,
  output logic sval,
  output logic done
);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t     state_reg;
  logic [3:0] hold_reg;
  logic [1:0] cnt_reg;
  logic       ready_reg;
  logic       sout_reg;
  logic       sval_reg;
  logic       done_reg;

  logic [3:0] word_in;
  assign word_in = {da, db, dc, dd};

  // Bit k of the serial stream; k counts transmitted bits, not register positions.
  function automatic logic pick(input logic [3:0] w, input logic [1:0] k);
    return MSB_FIRST ? w[2'd3 - k] : w[k];
  endfunction

  // Outputs are registered one state ahead so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      hold_reg  <= 4'b0000;
      cnt_reg   <= 2'd0;
      ready_reg <= 1'b1;
      sout_reg  <= 1'b0;
      sval_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load) begin
            hold_reg  <= word_in;
            cnt_reg   <= 2'd0;
            state_reg <= SHIFT;
            ready_reg <= 1'b0;
            sval_reg  <= 1'b1;
            sout_reg  <= pick(word_in, 2'd0);
          end
        end
        SHIFT: begin
          cnt_reg <= cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
`ifdef PISO_PARITY_EN
            state_reg <= PAR;
            sout_reg  <= ^hold_reg;
`else
            state_reg <= DONE;
            sout_reg  <= 1'b0;
            sval_reg  <= 1'b0;
            done_reg  <= 1'b1;
`endif
          end else begin
            sout_reg <= pick(hold_reg, cnt_reg + 2'd1);
          end
        end
`ifdef PISO_PARITY_EN
        PAR: begin
          state_reg <= DONE;
          sout_reg  <= 1'b0;
          sval_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
`endif
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          sout_reg  <= 1'b0;
          sval_reg  <= 1'b0;
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_reg;
  assign sout  = sout_reg;
  assign sval  = sval_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_piso_shift.sv
// Bench for piso_shift: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a queue-based model of the expected serial stream.
module tb_piso_shift;

`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk, rst, da, db, dc, dd, load;
  logic ready_m, sout_m, sval_m, done_m;
  logic ready_l, sout_l, sval_l, done_l;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic sm;
    logic sl;
    logic sval;
    logic done;
  } exp_t;

  // Pending per-cycle outputs after the most recent edge; empty means idle.
  exp_t exp_q[$];

  piso_shift #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .da(da), .db(db), .dc(dc), .dd(dd), .load(load),
    .ready(ready_m), .sout(sout_m), .sval(sval_m), .done(done_m)
  );

  piso_shift #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .da(da), .db(db), .dc(dc), .dd(dd), .load(load),
    .ready(ready_l), .sout(sout_l), .sval(sval_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string name, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s/%s: observed %b expected %b", tag, name, obs, expv);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    logic er;
    er = (exp_q.size() == 0);
    e  = er ? exp_t'(4'b0000) : exp_q[0];
    chk(tag, "ready_m", ready_m, er);
    chk(tag, "ready_l", ready_l, er);
    chk(tag, "sval_m",  sval_m,  e.sval);
    chk(tag, "sval_l",  sval_l,  e.sval);
    chk(tag, "done_m",  done_m,  e.done);
    chk(tag, "done_l",  done_l,  e.done);
    chk(tag, "sout_m",  sout_m,  e.sm);
    chk(tag, "sout_l",  sout_l,  e.sl);
  endtask

  task automatic push_word(input logic [3:0] w);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.sm = w[3-k];
      e.sl = w[k];
      e.sval = 1'b1;
      e.done = 1'b0;
      exp_q.push_back(e);
    end
    if (PAR_EN) begin
      e.sm = ^w;
      e.sl = ^w;
      e.sval = 1'b1;
      e.done = 1'b0;
      exp_q.push_back(e);
    end
    e = exp_t'(4'b0001);
    exp_q.push_back(e);
  endtask

  task automatic set_word(input logic [3:0] w);
    {da, db, dc, dd} = w;
  endtask

  // Inputs are set before the call; the model samples them at the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst) exp_q.delete();
    else if (exp_q.size() == 0) begin
      if (load) push_word({da, db, dc, dd});
    end else begin
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    compare(tag);
    $display("tick %-12s load=%b word=%b%b%b%b sout_m=%b sout_l=%b sval=%b done=%b ready=%b",
             tag, load, da, db, dc, dd, sout_m, sout_l, sval_m, done_m, ready_m);
  endtask

  initial begin
    rst = 1'b1;
    load = 1'($urandom);
    set_word(4'($urandom));
    #1 rst = 1'b0;
    #1 compare("reset_async");
    repeat (3) begin
      set_word(4'($urandom));
      load = 1'($urandom);
      tick("reset_hold");
    end

    rst = 1'b1;
    load = 1'b1;
    set_word(4'($urandom));
    tick("release_load");
    load = 1'b0;
    repeat (6) tick("release_run");

    set_word(4'b1011);
    load = 1'b1;
    tick("w1011_load");
    load = 1'b0;
    repeat (7) tick("w1011");

    set_word(4'b1100);
    load = 1'b1;
    tick("w1100_load");
    load = 1'b0;
    repeat (7) tick("w1100");

    set_word(4'b1000);
    load = 1'b1;
    tick("w1000_load");
    repeat (5) begin
      load = 1'($urandom);
      set_word(4'($urandom));
      tick("ignore");
    end
    load = 1'b0;
    repeat (4) tick("ignore_tail");

    load = 1'b1;
    for (int i = 0; i < 24; i++) begin
      set_word(((i / 2) % 2) != 0 ? 4'b1111 : 4'b0000);
      tick("hold_alt");
    end
    load = 1'b0;
    repeat (8) tick("hold_tail");

    repeat (60) begin
      load = ($urandom_range(2) == 0);
      set_word(4'($urandom));
      tick("random");
    end
    load = 1'b0;
    repeat (8) tick("random_tail");

    set_word(4'($urandom));
    load = 1'b1;
    tick("abort_load");
    load = 1'b0;
    tick("abort_b1");
    tick("abort_b2");
    #2 rst = 1'b0;
    #1 exp_q.delete();
    compare("abort_async");
    load = 1'b1;
    set_word(4'($urandom));
    tick("abort_hold");
    rst = 1'b1;
    set_word(4'($urandom));
    tick("fresh_load");
    load = 1'b0;
    repeat (7) tick("fresh");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
